fifo_unpack: RTL and testbench
==============================

# fifo_unpack

Word-to-nibble unpacking FIFO: the read-side counterpart of the nibble-packing flush FIFO. It accepts 32-bit words, each tagged with the index of its last valid nibble, buffers up to four of them, and presents them one 4-bit nibble per read, LSB nibble first. A level flush request drains all buffered words to the reader and then reports completion with a single-cycle pulse.

## Interface
- No parameters: depth fixed at 4 words, 8 nibbles per word.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_wr_valid_i  in  1  write strobe; one word per cycle.
- fifo_wr_data_i  in  32  word; nibble i = bits [4i+3:4i].
- fifo_wr_last_i  in  3  index of last valid nibble (0..7); nibbles above it are discarded.
- fifo_data_avail_o  out  1  a nibble is presented on fifo_rd_data_o.
- fifo_rd_valid_i  in  1  read strobe; consumes presented nibble.
- fifo_rd_data_o  out  4  current nibble (combinational from storage).
- fifo_rd_last_o  out  1  presented nibble is the last one of its word.
- fifo_flush_i  in  1  level flush request, held until done observed.
- fifo_flush_done_o  out  1  one-cycle pulse, drain complete.
- fifo_empty_o  out  1  no words stored.
- fifo_full_o  out  1  four words stored.

## Operation
- Storage: 4 entries × {32-bit data, 3-bit last index}. wr_ptr/rd_ptr are 3 bits (bit 2 = wrap bit), rd_col 3 bits.
- empty = (wr_ptr == rd_ptr); full = (wr_ptr[1:0] == rd_ptr[1:0]) & (wr_ptr[2] != rd_ptr[2]).
- Write accepted iff fifo_wr_valid_i & ~full & write-enable (see flush). Accepted: entry[wr_ptr[1:0]] <= {data, last}; wr_ptr += 1 (3-bit wrap).
- Write while full or not enabled: silently dropped, no state change.
- fifo_data_avail_o = ~empty. fifo_rd_data_o = entry[rd_ptr[1:0]].data[4·rd_col +: 4]; fifo_rd_last_o = avail & (rd_col == entry[rd_ptr[1:0]].last).
- Read accepted iff fifo_rd_valid_i & avail. If rd_last: rd_col <= 0, rd_ptr += 1; else rd_col += 1. Read when empty: ignored.
- Full/empty decided on registered pointers: read of the last nibble and write in the same cycle while full -> read accepted, write dropped. Write and read while empty -> write accepted, read ignored.
- Flush FSM (flush_q register holds previous fifo_flush_i; start = fifo_flush_i & ~flush_q):
  - IDLE: writes enabled. On start -> DRAIN. A write accepted in the start cycle belongs to the drained data.
  - DRAIN: writes disabled (dropped). Reads proceed normally. When empty (registered) -> DONE. If empty on entry, DONE follows after one DRAIN cycle.
  - DONE: fifo_flush_done_o = 1 for exactly this cycle; writes disabled; -> IDLE.
  - fifo_flush_i deasserting during DRAIN does not abort; drain completes and done still pulses. Start requires a new rising edge of fifo_flush_i.
- Reset: pointers, rd_col, flush_q = 0; FSM = IDLE. Storage not reset.

## Timing
- Reset values: fifo_empty_o=1, fifo_full_o=0, fifo_data_avail_o=0, fifo_rd_last_o=0, fifo_flush_done_o=0; fifo_rd_data_o undefined (storage not reset).
- Write-to-read latency: word written at edge N is readable (avail=1) in cycle N+1.
- Read: nibble presented combinationally; consumed at the edge where fifo_rd_valid_i=1; next nibble visible the following cycle. Back-to-back reads give one nibble/cycle.
- Flush: last nibble read at edge N -> empty in cycle N+1 (FSM samples) -> fifo_flush_done_o high in cycle N+2, low N+3.
- reset_n low mid-drain: immediate return to IDLE, FIFO empty, no done pulse.

## Test plan
- Reset, write 0x76543210 last=7, read 8 times -> nibbles 0,1,…,7; rd_last only on 7th index; empty after.
- Write 0xDEADBEEF last=2, then 0x000000A5 last=0 -> reads F,E,E (last on E), then 5 (last); total 4 nibbles.
- Write 5 words with no reads -> full after 4th, 5th dropped; drain reads match first 4 words only; wrap: then 4 more writes/reads still correct.
- Two words stored, assert flush; write during DRAIN dropped; read all nibbles -> done pulses exactly once 2 cycles after last read, FSM back to IDLE, writes accepted again.
- Flush with FIFO empty -> done pulses 2 cycles after flush rises; flush held high afterwards -> no second pulse.
- reset_n asserted during DRAIN with 3 words stored -> empty=1, done never pulses, next flush behaves normally.

Source files
------------

// File: rtl/fifo_unpack_if.sv
// Handshake bundle for the word-to-nibble unpacking FIFO.
// slave = FIFO side, master = producer/consumer side.
interface fifo_unpack_if;
   logic        fifo_wr_valid_i;
   logic [31:0] fifo_wr_data_i;
   logic [2:0]  fifo_wr_last_i;
   logic        fifo_data_avail_o;
   logic        fifo_rd_valid_i;
   logic [3:0]  fifo_rd_data_o;
   logic        fifo_rd_last_o;
   logic        fifo_flush_i;
   logic        fifo_flush_done_o;
   logic        fifo_empty_o;
   logic        fifo_full_o;

   modport slave (
      input  fifo_wr_valid_i, fifo_wr_data_i, fifo_wr_last_i,
      input  fifo_rd_valid_i, fifo_flush_i,
      output fifo_data_avail_o, fifo_rd_data_o, fifo_rd_last_o,
      output fifo_flush_done_o, fifo_empty_o, fifo_full_o
   );

   modport master (
      output fifo_wr_valid_i, fifo_wr_data_i, fifo_wr_last_i,
      output fifo_rd_valid_i, fifo_flush_i,
      input  fifo_data_avail_o, fifo_rd_data_o, fifo_rd_last_o,
      input  fifo_flush_done_o, fifo_empty_o, fifo_full_o
   );
endinterface

// File: rtl/fifo_unpack.sv
// Four-word FIFO that unpacks 32-bit words into 4-bit nibbles,
// LSB first, with a level-triggered drain-and-report flush.
module fifo_unpack (
   input  logic        clk,
   input  logic        reset_n,
   fifo_unpack_if.slave f
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [31:0] mem_data_q [4];
   logic [2:0]  mem_last_q [4];

   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] rd_col_q, rd_col_d;
   logic       flush_q, flush_d;
   logic [1:0] state_q, state_d;

   logic        empty, full;
   logic        wr_en, wr_acc, rd_acc;
   logic        start, rd_last;
   logic [1:0]  rd_idx;
   logic [31:0] cur_data;

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[1:0] == rd_ptr_q[1:0])
                 & (wr_ptr_q[2] != rd_ptr_q[2]);
   assign rd_idx = rd_ptr_q[1:0];
   assign cur_data = mem_data_q[rd_idx];
   assign rd_last  = ~empty & (rd_col_q == mem_last_q[rd_idx]);

   // Writes are only locked out once the drain has actually begun.
   assign wr_en  = (state_q == ST_IDLE);
   assign wr_acc = f.fifo_wr_valid_i & ~full & wr_en;
   assign rd_acc = f.fifo_rd_valid_i & ~empty;
   assign start  = f.fifo_flush_i & ~flush_q;

   assign f.fifo_data_avail_o = ~empty;
   assign f.fifo_rd_data_o    = cur_data[{rd_col_q, 2'b00} +: 4];
   assign f.fifo_rd_last_o    = rd_last;
   assign f.fifo_empty_o      = empty;
   assign f.fifo_full_o       = full;
   assign f.fifo_flush_done_o = (state_q == ST_DONE);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rd_col_d = rd_col_q;
      flush_d  = f.fifo_flush_i;
      state_d  = state_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 3'd1;
      if (rd_acc) begin
         if (rd_last) begin
            rd_col_d = 3'd0;
            rd_ptr_d = rd_ptr_q + 3'd1;
         end else begin
            rd_col_d = rd_col_q + 3'd1;
         end
      end
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_DRAIN;
         ST_DRAIN: if (empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         rd_col_q <= 3'd0;
         flush_q  <= 1'b0;
         state_q  <= ST_IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rd_col_q <= rd_col_d;
         flush_q  <= flush_d;
         state_q  <= state_d;
      end
   end

   // Storage carries no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_data_q[wr_ptr_q[1:0]] <= f.fifo_wr_data_i;
         mem_last_q[wr_ptr_q[1:0]] <= f.fifo_wr_last_i;
      end
   end
endmodule

// File: tb/tb_fifo_unpack.sv
// Directed + random bench for fifo_unpack against a nibble-queue
// reference model of the FIFO contents and flush handshake.
module tb_fifo_unpack;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fifo_unpack_if f ();

   fifo_unpack dut (
      .clk     (clk),
      .reset_n (reset_n),
      .f       (f)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: every stored nibble in read order, bit 4 = last of its word.
   logic [4:0] mq [$];
   logic m_drain, m_done, m_prev_fl;
   logic fl;

   function automatic int m_words();
      int n = 0;
      foreach (mq[i]) if (mq[i][4]) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_drain   = 1'b0;
      m_done    = 1'b0;
      m_prev_fl = 1'b0;
   endtask

   task automatic check_outs();
      logic av;
      av = (mq.size() != 0);
      chk("avail", {31'd0, f.fifo_data_avail_o}, {31'd0, av});
      chk("empty", {31'd0, f.fifo_empty_o}, {31'd0, ~av});
      chk("full", {31'd0, f.fifo_full_o}, {31'd0, m_words() == 4});
      chk("done", {31'd0, f.fifo_flush_done_o}, {31'd0, m_done});
      chk("rd_last", {31'd0, f.fifo_rd_last_o},
          {31'd0, av && mq[0][4]});
      if (av) chk("rd_data", {28'd0, f.fifo_rd_data_o}, {28'd0, mq[0][3:0]});
   endtask

   // One clock cycle: drive, check mid-cycle, advance the model at the edge.
   task automatic cyc(input logic wv, input logic [31:0] wd,
                      input logic [2:0] wl, input logic rv);
      logic full_m, empty_m, wen, start;
      f.fifo_wr_valid_i = wv;
      f.fifo_wr_data_i  = wd;
      f.fifo_wr_last_i  = wl;
      f.fifo_rd_valid_i = rv;
      f.fifo_flush_i    = fl;
      @(negedge clk);
      check_outs();
      full_m  = (m_words() == 4);
      empty_m = (mq.size() == 0);
      wen     = !m_drain && !m_done;
      start   = fl && !m_prev_fl && !m_drain && !m_done;
      if (rv && !empty_m) void'(mq.pop_front());
      if (wv && !full_m && wen)
         for (int i = 0; i <= int'(wl); i++)
            mq.push_back({i == int'(wl), wd[4*i +: 4]});
      m_done    = m_drain && empty_m;
      m_drain   = start || (m_drain && !empty_m);
      m_prev_fl = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] d, input logic [2:0] l);
      cyc(1'b1, d, l, 1'b0);
   endtask

   task automatic rd();
      cyc(1'b0, $urandom, 3'($urandom), 1'b1);
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 3'd0, 1'b0);
   endtask

   task automatic rd_all();
      for (int k = 0; k < 40 && mq.size() != 0; k++) rd();
      chk("drained", {31'd0, f.fifo_empty_o}, 32'd1);
   endtask

   initial begin
      m_reset();
      fl = 1'b0;
      f.fifo_wr_valid_i = 1'b0;
      f.fifo_wr_data_i  = 32'd0;
      f.fifo_wr_last_i  = 3'd0;
      f.fifo_rd_valid_i = 1'b0;
      f.fifo_flush_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      idle();

      // Full-word unpack, then partial words.
      wr(32'h7654_3210, 3'd7);
      for (int k = 0; k < 8; k++) begin
         if (mq.size() != 0)
            chk("seq_nib", {28'd0, f.fifo_rd_data_o}, k);
         rd();
      end
      idle();
      wr(32'hDEAD_BEEF, 3'd2);
      wr(32'h0000_00A5, 3'd0);
      repeat (5) rd();

      // Overfill, drain, then wrap the pointers.
      repeat (5) wr($urandom, 3'($urandom));
      rd_all();
      repeat (4) begin
         wr($urandom, 3'($urandom));
         rd_all();
      end
      cyc(1'b1, $urandom, 3'd1, 1'b1);
      repeat (3) wr($urandom, 3'd0);
      cyc(1'b1, $urandom, 3'd2, 1'b1);
      rd_all();

      // Flush with data stored; writes during drain are dropped.
      wr($urandom, 3'($urandom));
      wr($urandom, 3'($urandom));
      fl = 1'b1;
      wr($urandom, 3'd3);
      wr($urandom, 3'd3);
      rd_all();
      repeat (4) idle();
      fl = 1'b0;
      idle();
      wr($urandom, 3'($urandom));
      rd_all();

      // Flush of an empty FIFO, held high afterwards.
      fl = 1'b1;
      repeat (6) idle();
      fl = 1'b0;
      idle();

      // Reset in the middle of a drain.
      repeat (3) wr($urandom, 3'($urandom));
      fl = 1'b1;
      repeat (2) idle();
      f.fifo_flush_i = 1'b0;
      fl = 1'b0;
      reset_n = 1'b0;
      #2;
      m_reset();
      check_outs();
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) idle();
      wr($urandom, 3'($urandom));
      fl = 1'b1;
      idle();
      rd_all();
      repeat (3) idle();
      fl = 1'b0;

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 24) == 0) fl = ~fl;
         cyc(1'($urandom_range(0, 2) != 0), $urandom, 3'($urandom),
             1'($urandom_range(0, 3) != 0));
      end
      fl = 1'b0;
      rd_all();
      repeat (4) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
